// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// datapath mux selects and the packed control word.
package mips_ctrl_pkg;

    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] ST_MEM_READ  = 4'd3;
    localparam logic [3:0] ST_MEM_WB    = 4'd4;
    localparam logic [3:0] ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTE   = 4'd6;
    localparam logic [3:0] ST_ALU_WB    = 4'd7;
    localparam logic [3:0] ST_BRANCH    = 4'd8;
    localparam logic [3:0] ST_JUMP      = 4'd9;
    localparam logic [3:0] ST_ADDI_EX   = 4'd10;
    localparam logic [3:0] ST_ADDI_WB   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode for the multi-cycle FSM. Mostly Moore,
// with mem_ready gating the FETCH loads and the store's completion pulse.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
                if (!is_legal_op(opcode)) begin
                    ctrl.illegal_op = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            ST_MEM_ADDR, ST_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: state register, next-state
// logic, and reset gating of the decoded control word.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [3:0]         state_out
);

    logic [3:0] state;
    logic [3:0] next_state;
    ctrl_t      dec_ctrl;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_FETCH;
        case (state)
            ST_FETCH:     next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = ST_EXECUTE;
                    OP_LW, OP_SW: next_state = ST_MEM_ADDR;
                    OP_BEQ:       next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
                    OP_ADDI:      next_state = ST_ADDI_EX;
                    default:      next_state = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    next_state = ST_MEM_READ;
                end else if (opcode == OP_SW) begin
                    next_state = ST_MEM_WRITE;
                end
            end
            ST_MEM_READ:  next_state = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WRITE: next_state = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXECUTE:   next_state = ST_ALU_WB;
            ST_ADDI_EX:   next_state = ST_ADDI_WB;
            default:      next_state = ST_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (dec_ctrl)
    );

    // Reset masks every output immediately so an abandoned instruction never writes
    assign ctrl      = rst ? '0 : dec_ctrl;
    assign state_out = rst ? ST_FETCH : state;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes the
// expected state and control word, which are popped and compared mid-cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_out;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state_out     (state_out)
    );

    // Reference control word for a state, written straight from the state table
    function automatic logic [17:0] expected_ctrl(input logic [3:0] st, input logic mr,
                                                  input logic [5:0] op);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, id, ill;
        logic [1:0] asb, aop, psrc;
        logic legal;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, id, ill} = '0;
        asb = 2'b00;
        aop = 2'b00;
        psrc = 2'b00;
        legal = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) ||
                (op == 6'd4) || (op == 6'd2) || (op == 6'd8);
        case (st)
            4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            4'd1: begin asb = 2'b11; ill = !legal; id = !legal; end
            4'd2, 4'd10: begin asa = 1; asb = 2'b10; end
            4'd3: begin mrd = 1; iod = 1; end
            4'd4: begin rw = 1; m2r = 1; id = 1; end
            4'd5: begin mwr = 1; iod = 1; id = mr; end
            4'd6: begin asa = 1; aop = 2'b10; end
            4'd7: begin rw = 1; rdst = 1; id = 1; end
            4'd8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; id = 1; end
            4'd9: begin pw = 1; psrc = 2'b10; id = 1; end
            4'd11: begin rw = 1; id = 1; end
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, id, ill};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs, push the expectation for the current state,
    // then pop and compare once the combinational outputs have settled.
    task automatic applyStimulus(input string tag, input logic r, input logic [5:0] op,
                                 input logic mr, input logic [3:0] exp_state);
        exp_t e;
        exp_t got;
        logic [17:0] act;
        @(negedge clk);
        rst = r;
        opcode = op;
        mem_ready = mr;
        e.st = r ? 4'd0 : exp_state;
        e.ctrl = r ? 18'd0 : expected_ctrl(exp_state, mr, op);
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
               illegal_op};
        checkOutput({tag, "_state"}, {28'd0, state_out}, {28'd0, got.st});
        checkOutput({tag, "_ctrl"}, {14'd0, act}, {14'd0, got.ctrl});
        checkOutput({tag, "_rdwr"}, {31'd0, mem_read & mem_write}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        opcode = 6'd0;
        mem_ready = 1'b0;

        applyStimulus("rst0", 1, 6'd0, 0, 4'd0);
        applyStimulus("rst1", 1, 6'd0, 1, 4'd0);
        applyStimulus("fetch_wait", 0, 6'd0, 0, 4'd0);

        applyStimulus("r_fetch", 0, 6'd0, 1, 4'd0);
        applyStimulus("r_dec", 0, 6'd0, 1, 4'd1);
        applyStimulus("r_exe", 0, 6'd0, 1, 4'd6);
        applyStimulus("r_wb", 0, 6'd0, 1, 4'd7);

        applyStimulus("lw_fetch", 0, 6'd35, 1, 4'd0);
        applyStimulus("lw_dec", 0, 6'd35, 1, 4'd1);
        applyStimulus("lw_addr", 0, 6'd35, 1, 4'd2);
        for (int i = 0; i < 3; i++) applyStimulus("lw_wait", 0, 6'd35, 0, 4'd3);
        applyStimulus("lw_read", 0, 6'd35, 1, 4'd3);
        applyStimulus("lw_wb", 0, 6'd35, 1, 4'd4);

        applyStimulus("sw_fetch", 0, 6'd43, 1, 4'd0);
        applyStimulus("sw_dec", 0, 6'd43, 1, 4'd1);
        applyStimulus("sw_addr", 0, 6'd43, 1, 4'd2);
        applyStimulus("sw_write", 0, 6'd43, 1, 4'd5);

        applyStimulus("beq_fetch", 0, 6'd4, 1, 4'd0);
        applyStimulus("beq_dec", 0, 6'd4, 1, 4'd1);
        applyStimulus("beq_br", 0, 6'd4, 1, 4'd8);

        applyStimulus("j_fetch", 0, 6'd2, 1, 4'd0);
        applyStimulus("j_dec", 0, 6'd2, 1, 4'd1);
        applyStimulus("j_jump", 0, 6'd2, 1, 4'd9);

        applyStimulus("ill_fetch", 0, 6'd63, 1, 4'd0);
        applyStimulus("ill_dec", 0, 6'd63, 1, 4'd1);

        applyStimulus("addi_fetch", 0, 6'd8, 1, 4'd0);
        applyStimulus("addi_dec", 0, 6'd8, 1, 4'd1);
        applyStimulus("addi_ex", 0, 6'd8, 1, 4'd10);
        applyStimulus("addi_wb", 0, 6'd8, 1, 4'd11);

        applyStimulus("swr_fetch", 0, 6'd43, 1, 4'd0);
        applyStimulus("swr_dec", 0, 6'd43, 1, 4'd1);
        applyStimulus("swr_addr", 0, 6'd43, 1, 4'd2);
        applyStimulus("swr_wait", 0, 6'd43, 0, 4'd5);
        applyStimulus("swr_rst", 1, 6'd43, 1, 4'd0);
        applyStimulus("swr_rst2", 1, 6'd43, 1, 4'd0);
        applyStimulus("swr_after", 0, 6'd43, 0, 4'd0);
        applyStimulus("swr_refetch", 0, 6'd0, 1, 4'd0);
        applyStimulus("swr_redec", 0, 6'd0, 1, 4'd1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
